// File: rtl/pipelined_adder_if.sv
// Operand/result bus of the pipelined adder.
//
// Handshake: each side (in_* and out_*) follows strict valid/ready rules.
// A transfer happens on a rising clock edge where valid and ready are both 1.
// While valid is high and ready is low, the sender holds valid and every
// payload field stable. valid never waits on ready. ready may depend
// combinationally on the other side's ready (in_ready follows out_ready).
`timescale 1ns/1ps
interface pipelined_adder_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] y;
  logic         cout;
  logic         ovf;

  // Adder side: consumes operands and produces results.
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, y, cout, ovf
  );

  // Producer/consumer side.
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, y, cout, ovf
  );
endinterface

// File: rtl/pipelined_adder.sv
// Segmented-carry pipelined adder/subtractor.
// The N-bit operands are cut into SEGS slices of W = N/SEGS bits. Stage k adds
// slice k using the carry registered by stage k-1, so the longest carry chain
// is W+1 bits. One operation per clock; stalls propagate back through the
// stage valid bits, and bubbles collapse upstream of a stall.
// Optional macro PIPELINED_ADDER_SAT_EN: clamp y to the signed limit on
// overflow (ovf/cout still describe the unclamped sum).
`timescale 1ns/1ps
module pipelined_adder #(
  parameter int N    = 32,
  parameter int SEGS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipelined_adder_if.slave      bus
);

  localparam int W = (SEGS >= 1) ? N / SEGS : N;

  generate
    if (SEGS < 1 || (N % ((SEGS >= 1) ? SEGS : 1)) != 0) begin : g_bad_cfg
      $fatal(1, "pipelined_adder: SEGS must be >= 1 and divide N");
    end
  endgenerate

  // Stage registers. a_q/b_q carry the not-yet-added operand slices (b already
  // inverted for subtraction), r_q the finished result slices, c_q the carry
  // out of the slice this stage added.
  logic [SEGS-1:0]         v_q;
  logic [SEGS-1:0][N-1:0]  a_q;
  logic [SEGS-1:0][N-1:0]  b_q;
  logic [SEGS-1:0][N-1:0]  r_q;
  logic [SEGS-1:0]         c_q;

  // Values presented to each stage by its upstream neighbour.
  logic [SEGS-1:0]         src_v;
  logic [SEGS-1:0][N-1:0]  src_a;
  logic [SEGS-1:0][N-1:0]  src_b;
  logic [SEGS-1:0][N-1:0]  src_r;
  logic [SEGS-1:0]         src_c;

  // Next-state contents computed for each stage.
  logic [SEGS-1:0][W:0]    sum_d;
  logic [SEGS-1:0][N-1:0]  r_d;
  logic [SEGS-1:0]         c_d;

  logic [SEGS-1:0]         load;
  logic                    full_tail;
  logic [N-1:0]            b_eff;
  logic                    c0;

  logic [N-1:0]            y_raw;
  logic                    a_top;
  logic                    b_top;
  logic                    ovf_w;

  assign b_eff = bus.sub ? ~bus.b : bus.b;
  assign c0    = bus.sub | bus.cin;

  // Route each stage's input: stage 0 from the bus, stage k from stage k-1.
  always_comb begin
    src_v    = '0;
    src_a    = '0;
    src_b    = '0;
    src_r    = '0;
    src_c    = '0;
    src_v[0] = bus.in_valid;
    src_a[0] = bus.a;
    src_b[0] = b_eff;
    src_c[0] = c0;
    for (int k = 1; k < SEGS; k++) begin
      src_v[k] = v_q[k-1];
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_r[k] = r_q[k-1];
      src_c[k] = c_q[k-1];
    end
  end

  // Add slice k with the incoming carry and splice it into the result.
  always_comb begin
    sum_d = '0;
    r_d   = '0;
    c_d   = '0;
    for (int k = 0; k < SEGS; k++) begin
      sum_d[k] = {1'b0, src_a[k][k*W +: W]} + {1'b0, src_b[k][k*W +: W]}
               + {{W{1'b0}}, src_c[k]};
      r_d[k]   = src_r[k];
      r_d[k][k*W +: W] = sum_d[k][W-1:0];
      c_d[k]   = sum_d[k][W];
    end
  end

  // A stage may load unless it and every stage after it are full while the
  // consumer is not ready; this is the adv/ready chain written in closed form.
  always_comb begin
    load      = '0;
    full_tail = 1'b1;
    for (int k = 0; k < SEGS; k++) begin
      full_tail = 1'b1;
      for (int j = k; j < SEGS; j++) begin
        full_tail = full_tail & v_q[j];
      end
      load[k] = bus.out_ready | ~full_tail;
    end
  end

  assign bus.in_ready = load[0];

  // Stage registers: advance where allowed, hold every field when stalled.
  // Payload is only written for a valid incoming op so idle outputs stay quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      a_q <= '0;
      b_q <= '0;
      r_q <= '0;
      c_q <= '0;
    end else begin
      for (int k = 0; k < SEGS; k++) begin
        if (load[k]) begin
          v_q[k] <= src_v[k];
          if (src_v[k]) begin
            a_q[k] <= src_a[k];
            b_q[k] <= src_b[k];
            r_q[k] <= r_d[k];
            c_q[k] <= c_d[k];
          end
        end
      end
    end
  end

  // Output flags come from the last stage; the sign bits of a and b_eff
  // travel down the pipe with the operands.
  assign y_raw = r_q[SEGS-1];
  assign a_top = a_q[SEGS-1][N-1];
  assign b_top = b_q[SEGS-1][N-1];
  assign ovf_w = (a_top == b_top) & (y_raw[N-1] != a_top);

  assign bus.out_valid = v_q[SEGS-1];
  assign bus.cout      = c_q[SEGS-1];
  assign bus.ovf       = ovf_w;

`ifdef PIPELINED_ADDER_SAT_EN
  // On overflow the true result lies beyond the limit on a's side.
  assign bus.y = ovf_w ? {a_top, {(N-1){~a_top}}} : y_raw;
`else
  assign bus.y = y_raw;
`endif

endmodule
